// File: rtl/uart_fifo.sv
// uart_fifo: full-duplex UART (start, DATA_W bits LSB first, optional even parity under UART_PARITY_EN, stop bits)
// with TX/RX FIFOs; wr_rdy drops when the TX FIFO is full, and a byte arriving at a full RX FIFO is dropped with an overrun pulse.

module uart_fifo_buf #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_q, rd_q;
   logic         do_push, do_pop;

   // The extra pointer MSB distinguishes full (wrap bits differ) from empty.
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty_o = (wr_q == rd_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
            wr_q                <= wr_q + 1'b1;
         end
         if (do_pop) rd_q <= rd_q + 1'b1;
      end
   end
endmodule

module uart_fifo #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   output logic              wr_rdy,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              rd_rdy,
   input  logic              rx,
   output logic              tx,
   output logic              frame_err,
   output logic              overrun,
   output logic              parity_err
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HI
   } state_t;

`ifdef UART_PARITY_EN
   localparam state_t ST_AFTER_DATA = ST_PARITY;
`else
   localparam state_t ST_AFTER_DATA = ST_STOP;
`endif

   state_t            tx_state_q, tx_state_d;
   logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]     tx_bit_q, tx_bit_d;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0] tx_head;
   logic              tx_full, tx_empty, tx_pop, tx_line, tx_par;

   state_t            rx_state_q, rx_state_d;
   logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]     rx_bit_q, rx_bit_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic              rx_meta_q, rx_s_q;
   logic              rx_full, rx_empty, rx_push, rx_par_bad;
   logic              frame_err_q, frame_err_d;
   logic              overrun_q, overrun_d;
   logic              parity_err_q, parity_err_d;

   uart_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst_n(rst_n), .push_i(wr_en), .din_i(din), .pop_i(tx_pop),
      .dout_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
   );

   uart_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst_n(rst_n), .push_i(rx_push), .din_i(rx_sh_q), .pop_i(rd_en),
      .dout_o(dout), .full_o(rx_full), .empty_o(rx_empty)
   );

   assign wr_rdy     = !tx_full;
   assign rd_rdy     = !rx_empty;
   assign tx         = tx_line;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign parity_err = parity_err_q;

`ifdef UART_PARITY_EN
   logic tx_par_q, tx_par_d, rx_par_bad_q, rx_par_bad_d;
   // Parity is latched at load because the shifter is consumed during DATA.
   assign tx_par_d     = tx_pop ? ^tx_head : tx_par_q;
   assign rx_par_bad_d = (rx_state_q == ST_PARITY && rx_cnt_q == CNT_LAST)
                         ? (rx_s_q ^ (^rx_sh_q)) : rx_par_bad_q;
   assign tx_par       = tx_par_q;
   assign rx_par_bad   = rx_par_bad_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_par_q     <= 1'b0;
         rx_par_bad_q <= 1'b0;
      end else begin
         tx_par_q     <= tx_par_d;
         rx_par_bad_q <= rx_par_bad_d;
      end
   end
`else
   assign tx_par     = 1'b0;
   assign rx_par_bad = 1'b0;
`endif

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + CW'(1);
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_pop     = 1'b0;
      tx_line    = 1'b1;
      case (tx_state_q)
         ST_IDLE: begin
            tx_cnt_d = '0;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_sh_d    = tx_head;
               tx_state_d = ST_START;
            end
         end
         ST_START: begin
            tx_line = 1'b0;
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            tx_line = tx_sh_q[0];
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d = '0;
               tx_sh_d  = tx_sh_q >> 1;
               if (tx_bit_q == BIT_LAST) begin
                  tx_bit_d   = '0;
                  tx_state_d = ST_AFTER_DATA;
               end else begin
                  tx_bit_d = tx_bit_q + BW'(1);
               end
            end
         end
         ST_PARITY: begin
            tx_line = tx_par;
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == STOP_LAST) begin
                  tx_bit_d = '0;
                  // Chain straight into the next start bit so bursts have no idle gap.
                  if (!tx_empty) begin
                     tx_pop     = 1'b1;
                     tx_sh_d    = tx_head;
                     tx_state_d = ST_START;
                  end else begin
                     tx_state_d = ST_IDLE;
                  end
               end else begin
                  tx_bit_d = tx_bit_q + BW'(1);
               end
            end
         end
         default: tx_state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q + CW'(1);
      rx_bit_d     = rx_bit_q;
      rx_sh_d      = rx_sh_q;
      rx_push      = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
      parity_err_d = 1'b0;
      case (rx_state_q)
         ST_IDLE: begin
            rx_cnt_d = '0;
            if (!rx_s_q) rx_state_d = ST_START;
         end
         ST_START: begin
            // Half-bit sample rejects glitches and aligns later samples to mid-bit.
            if (rx_cnt_q == CNT_HALF) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s_q, rx_sh_q[DATA_W-1:1]};
               if (rx_bit_q == BIT_LAST) begin
                  rx_bit_d   = '0;
                  rx_state_d = ST_AFTER_DATA;
               end else begin
                  rx_bit_d = rx_bit_q + BW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d = '0;
               if (!rx_s_q) begin
                  frame_err_d  = 1'b1;
                  parity_err_d = rx_par_bad;
                  rx_state_d   = ST_WAIT_HI;
               end else begin
                  rx_state_d = ST_IDLE;
                  if (rx_par_bad)   parity_err_d = 1'b1;
                  else if (rx_full) overrun_d    = 1'b1;
                  else              rx_push      = 1'b1;
               end
            end
         end
         ST_WAIT_HI: begin
            rx_cnt_d = '0;
            if (rx_s_q) rx_state_d = ST_IDLE;
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q   <= ST_IDLE;
         tx_cnt_q     <= '0;
         tx_bit_q     <= '0;
         tx_sh_q      <= '0;
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         rx_state_q   <= ST_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_sh_q      <= '0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_sh_q      <= tx_sh_d;
         rx_meta_q    <= rx;
         rx_s_q       <= rx_meta_q;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_sh_q      <= rx_sh_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         parity_err_q <= parity_err_d;
      end
   end
endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: instance A runs in loopback, cross-wired with B, or driven directly;
// expected RX bytes are queued when driven and compared when popped.

module tb_uart_fifo;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en_a, wr_en_b, rd_en_a, rd_en_b;
   logic [7:0] din_a, din_b, dout_a, dout_b;
   logic       wr_rdy_a, wr_rdy_b, rd_rdy_a, rd_rdy_b;
   logic       rx_a, rx_b, tx_a, tx_b, rx_drv;
   logic       fe_a, fe_b, ov_a, ov_b, pe_a, pe_b;
   logic [1:0] mode;  // 0 loopback, 1 cross-wired A<->B, 2 A.rx driven by bench

   int         errors = 0;
   int         checks = 0;
   int         fe_a_hi = 0, ov_a_hi = 0, pe_a_hi = 0, b_pulse_hi = 0;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];

`ifdef UART_PARITY_EN
   localparam int NF = 11;
`else
   localparam int NF = 10;
`endif

   always #5 clk = ~clk;

   assign rx_a = (mode == 2'd0) ? tx_a : (mode == 2'd1) ? tx_b : rx_drv;
   assign rx_b = (mode == 2'd1) ? tx_a : 1'b1;

   uart_fifo u_a (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .din(din_a), .wr_rdy(wr_rdy_a),
      .rd_en(rd_en_a), .dout(dout_a), .rd_rdy(rd_rdy_a), .rx(rx_a), .tx(tx_a),
      .frame_err(fe_a), .overrun(ov_a), .parity_err(pe_a)
   );

   uart_fifo u_b (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .din(din_b), .wr_rdy(wr_rdy_b),
      .rd_en(rd_en_b), .dout(dout_b), .rd_rdy(rd_rdy_b), .rx(rx_b), .tx(tx_b),
      .frame_err(fe_b), .overrun(ov_b), .parity_err(pe_b)
   );

   always @(negedge clk) begin
      fe_a_hi    <= fe_a_hi + int'(fe_a);
      ov_a_hi    <= ov_a_hi + int'(ov_a);
      pe_a_hi    <= pe_a_hi + int'(pe_a);
      b_pulse_hi <= b_pulse_hi + int'(fe_b) + int'(ov_b) + int'(pe_b);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NF-1:0] frame(input logic [7:0] d);
`ifdef UART_PARITY_EN
      return {1'b1, ^d, d, 1'b0};
`else
      return {1'b1, d, 1'b0};
`endif
   endfunction

   task automatic send_bits(input logic [NF-1:0] f);
      for (int b = 0; b < NF; b++) begin
         rx_drv = f[b];
         repeat (16) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   task automatic push_a(input logic [7:0] d);
      wr_en_a = 1'b1;
      din_a   = d;
      @(negedge clk);
      wr_en_a = 1'b0;
   endtask

   task automatic wait_rd_a(input string tag, input int max, output int cyc);
      cyc = 0;
      while (!rd_rdy_a && cyc < max) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_timeout"}, rd_rdy_a, 1'b1);
   endtask

   task automatic pop_a(input string tag);
      logic [7:0] exp;
      exp = (q_a.size() != 0) ? q_a.pop_front() : 8'hxx;
      check({tag, "_rdy"}, rd_rdy_a, 1'b1);
      check(tag, dout_a, exp);
      rd_en_a = 1'b1;
      @(negedge clk);
      rd_en_a = 1'b0;
   endtask

   task automatic pop_b(input string tag);
      logic [7:0] exp;
      exp = (q_b.size() != 0) ? q_b.pop_front() : 8'hxx;
      check({tag, "_rdy"}, rd_rdy_b, 1'b1);
      check(tag, dout_b, exp);
      rd_en_b = 1'b1;
      @(negedge clk);
      rd_en_b = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc, hi, fe0, ov0, pe0;
      logic [NF-1:0] fr;

      rst_n = 1'b0; mode = 2'd0; rx_drv = 1'b1;
      wr_en_a = 1'b0; wr_en_b = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
      din_a = '0; din_b = '0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx_a, 1'b1);
      check("rst_wr_rdy", wr_rdy_a, 1'b1);
      check("rst_rd_rdy", rd_rdy_a, 1'b0);
      check("rst_dout", dout_a, 8'h00);
      check("rst_pulses", {fe_a, ov_a, pe_a}, 3'b000);
      check("rst_tx_b", tx_b, 1'b1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 1: loopback single byte, tx low two edges after the push edge
      q_a.push_back(8'hE8);
      push_a(8'hE8);
      check("t1_tx_idle_at_pop", tx_a, 1'b1);
      @(negedge clk);
      check("t1_tx_start", tx_a, 1'b0);
      wait_rd_a("t1_rx", 300, cyc);
      check("t1_latency_150_170", (cyc + 2 >= 150) && (cyc + 2 <= 170), 1'b1);
      pop_a("t1_dout");
      check("t1_rd_rdy_after_pop", rd_rdy_a, 1'b0);

      // 2: cross-wired pair, simultaneous pushes
      mode = 2'd1;
      @(negedge clk);
      q_b.push_back(8'hCA);
      q_a.push_back(8'h4B);
      wr_en_a = 1'b1; din_a = 8'hCA; wr_en_b = 1'b1; din_b = 8'h4B;
      @(negedge clk);
      wr_en_a = 1'b0; wr_en_b = 1'b0;
      cyc = 0;
      while (!(rd_rdy_a && rd_rdy_b) && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      check("t2_timeout", rd_rdy_a && rd_rdy_b, 1'b1);
      pop_b("t2_b_dout");
      pop_a("t2_a_dout");

      // 3/4: 8-cycle write burst into a 4-deep FIFO; 5 accepted, no read, 5th frame overruns
      mode = 2'd0;
      repeat (4) @(negedge clk);
      ov0 = ov_a_hi; fe0 = fe_a_hi;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t3_wr_rdy_%0d", i), wr_rdy_a, (i < 5));
         wr_en_a = 1'b1;
         din_a   = 8'(i + 1);
         @(negedge clk);
      end
      wr_en_a = 1'b0;
      hi = 0;
      for (int k = 0; k < 794; k++) begin
         if (tx_a) hi++;
         @(negedge clk);
      end
      // data 01..05 carry 7 one-bits plus 5 stop bits, 16 cycles each
      check("t3_tx_high_cycles", hi, 192);
      repeat (40) @(negedge clk);
      check("t4_overrun_once", ov_a_hi - ov0, 1);
      check("t4_no_frame_err", fe_a_hi - fe0, 0);
      for (int i = 1; i <= 4; i++) q_a.push_back(8'(i));
      for (int i = 0; i < 4; i++) pop_a($sformatf("t4_pop_%0d", i));
      check("t4_empty_after_pops", rd_rdy_a, 1'b0);

      // 5: directly driven RX line
      mode = 2'd2;
      repeat (4) @(negedge clk);
      fe0 = fe_a_hi; pe0 = pe_a_hi;
      fr = frame(8'hA5);
      fr[NF-1] = 1'b0;
      send_bits(fr);
      repeat (30) @(negedge clk);
      check("t5_frame_err_1cyc", fe_a_hi - fe0, 1);
      check("t5_bad_stop_parity", pe_a_hi - pe0, 0);
      check("t5_bad_stop_no_push", rd_rdy_a, 1'b0);
      q_a.push_back(8'h3C);
      send_bits(frame(8'h3C));
      wait_rd_a("t5_good", 40, cyc);
      pop_a("t5_good_dout");
      fe0 = fe_a_hi;
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (200) @(negedge clk);
      check("t5_glitch_no_push", rd_rdy_a, 1'b0);
      check("t5_glitch_no_frame_err", fe_a_hi - fe0, 0);
      q_a.push_back(8'h81);
      send_bits(frame(8'h81));
      wait_rd_a("t5_rearm", 40, cyc);
      pop_a("t5_rearm_dout");
`ifdef UART_PARITY_EN
      pe0 = pe_a_hi; fe0 = fe_a_hi;
      fr = frame(8'h5A);
      fr[NF-2] = ~fr[NF-2];
      send_bits(fr);
      repeat (30) @(negedge clk);
      check("t5_parity_err", pe_a_hi - pe0, 1);
      check("t5_parity_no_frame_err", fe_a_hi - fe0, 0);
      check("t5_parity_no_push", rd_rdy_a, 1'b0);
`endif

      // 6: reset in the middle of a data bit on both TX and RX
      mode = 2'd0;
      repeat (4) @(negedge clk);
      push_a(8'h99);
      repeat (60) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_tx_during_rst", tx_a, 1'b1);
      check("t6_rd_rdy_during_rst", rd_rdy_a, 1'b0);
      check("t6_wr_rdy_during_rst", wr_rdy_a, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      check("t6_tx_idle_after", tx_a, 1'b1);
      check("t6_no_partial_byte", rd_rdy_a, 1'b0);
      q_a.push_back(8'h55);
      push_a(8'h55);
      wait_rd_a("t6_fresh", 300, cyc);
      pop_a("t6_fresh_dout");

      check("b_no_error_pulses", b_pulse_hi, 0);
`ifndef UART_PARITY_EN
      check("parity_err_never", pe_a_hi, 0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
